// File: rtl/tiny_acc_core.sv
// tiny_acc_core: two-stage (fetch/decode, execute/writeback) accumulator processor
// with idle/run/halt control, program-load port, retired counter and debug read port.
module tiny_acc_core #(
  parameter int DATA_W     = 8,
  parameter int OPND_W     = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 15,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [OPND_W-1:0] prog_addr,
  input  logic [OPND_W+3:0] prog_data,
  output logic              prog_ready,
  input  logic [OPND_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [OPND_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int INST_W = OPND_W + 4;
  localparam logic [OPND_W:0]   IMEM_LIM = (OPND_W+1)'(IMEM_DEPTH);
  localparam logic [OPND_W:0]   DMEM_LIM = (OPND_W+1)'(DMEM_DEPTH);
  localparam logic [OPND_W-1:0] PC_LAST  = OPND_W'(IMEM_DEPTH - 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_NAND = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_BNZ  = 4'h3;
  localparam logic [3:0] OP_LI   = 4'h4;
  localparam logic [3:0] OP_SLLI = 4'h5;
  localparam logic [3:0] OP_SRLI = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;
  localparam logic [3:0] OP_LA   = 4'hE;
  localparam logic [3:0] OP_SA   = 4'hF;

  // Opcode 9 has no architectural effect, so it doubles as the bubble instruction.
  localparam logic [INST_W-1:0] NOP_INST = INST_W'(9);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  state_t state, state_nx;

  logic [INST_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [INST_W-1:0] ir;
  logic              ir_valid;

  logic [3:0]        ex_op;
  logic [OPND_W-1:0] ex_opnd;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_mem;
  logic [31:0]       shamt;
  logic [DATA_W-1:0] alu_res;
  logic              ex_halt;
  logic              ex_store;

  logic [INST_W-1:0] f_inst;
  logic [3:0]        f_op;
  logic [OPND_W-1:0] f_opnd;
  logic [OPND_W-1:0] pc_inc;
  logic [OPND_W-1:0] pc_fetch_nx;

  function automatic logic in_dmem(input logic [OPND_W-1:0] a);
    return {1'b0, a} < DMEM_LIM;
  endfunction

  assign ex_op    = ir[3:0];
  assign ex_opnd  = ir[INST_W-1:4];
  assign ex_imm   = DATA_W'($signed(ex_opnd));
  assign ex_mem   = in_dmem(ex_opnd) ? dmem[ex_opnd] : '0;
  assign shamt    = 32'(ex_opnd) % DATA_W;
  assign ex_halt  = ir_valid && (ex_op == OP_HALT);
  assign ex_store = ir_valid && (ex_op == OP_SA) && in_dmem(ex_opnd);

  always_comb begin
    alu_res = acc;
    if (ir_valid) begin
      case (ex_op)
        OP_ADD:  alu_res = ex_mem + acc;
        OP_NAND: alu_res = ~(ex_mem & acc);
        OP_ADDI: alu_res = acc + ex_imm;
        OP_LI:   alu_res = ex_imm;
        OP_SLLI: alu_res = acc << shamt;
        OP_SRLI: alu_res = acc >> shamt;
        OP_SUB:  alu_res = acc - ex_mem;
        OP_LA:   alu_res = ex_mem;
        default: alu_res = acc;
      endcase
    end
  end

  // BNZ resolves at fetch using the result the execute stage is producing this cycle.
  assign f_inst = imem[pc];
  assign f_op   = f_inst[3:0];
  assign f_opnd = f_inst[INST_W-1:4];
  assign pc_inc = (pc == PC_LAST) ? '0 : pc + 1'b1;

  always_comb begin
    pc_fetch_nx = pc_inc;
    if (f_op == OP_BNZ && alu_res != '0) begin
      pc_fetch_nx = ({1'b0, f_opnd} < IMEM_LIM) ? f_opnd : '0;
    end else if (f_op == OP_HALT) begin
      pc_fetch_nx = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    running    = 1'b0;
    halted     = 1'b0;
    prog_ready = 1'b1;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        running    = 1'b1;
        prog_ready = 1'b0;
        if (ex_halt) state_nx = ST_HALT;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) state_nx = ST_RUN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= '0;
      acc      <= '0;
      ir       <= NOP_INST;
      ir_valid <= 1'b0;
      retired  <= '0;
      imem     <= '{default: '0};
      dmem     <= '{default: '0};
    end else begin
      if (prog_we && prog_ready && ({1'b0, prog_addr} < IMEM_LIM)) imem[prog_addr] <= prog_data;
      if (state == ST_RUN) begin
        ir       <= f_inst;
        ir_valid <= 1'b1;
        pc       <= pc_fetch_nx;
        acc      <= alu_res;
        if (ex_store) dmem[ex_opnd] <= acc;
        if (ir_valid && retired != '1) retired <= retired + 1'b1;
      end else begin
        ir       <= NOP_INST;
        ir_valid <= 1'b0;
        if (start) begin
          pc      <= '0;
          retired <= '0;
        end
      end
    end
  end

  assign dbg_data = in_dmem(dbg_addr) ? dmem[dbg_addr] : DATA_W'(pc);

endmodule

// File: tb/tb_tiny_acc_core.sv
// tb_tiny_acc_core: scoreboard bench for tiny_acc_core; expected values are queued
// as each program is launched and popped once the core reaches the observed point.
module tb_tiny_acc_core;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [3:0] pc;
  logic [7:0] acc;
  logic       running;
  logic       halted;
  logic [15:0] retired;

  localparam int K_ACC     = 0;
  localparam int K_PC      = 1;
  localparam int K_RET     = 2;
  localparam int K_HALTED  = 3;
  localparam int K_RUNNING = 4;
  localparam int K_READY   = 5;
  localparam int K_DBG     = 6;

  string       sbTag[$];
  int          sbKind[$];
  int          sbArg[$];
  logic [31:0] sbExp[$];
  logic [7:0]  progQ[$];

  int checks = 0;
  int errors = 0;
  int cyc;

  tiny_acc_core dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ready(prog_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .acc(acc), .running(running), .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge and are held across the next rising edge.
  task automatic applyStimulus(input logic we, input logic [3:0] a, input logic [7:0] d, input logic st);
    prog_we   = we;
    prog_addr = a;
    prog_data = d;
    start     = st;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
  endtask

  task automatic loadProg();
    foreach (progQ[i]) applyStimulus(1'b1, 4'(i), progQ[i], 1'b0);
  endtask

  task automatic pushExp(input string tag, input int kind, input int arg, input logic [31:0] exp);
    sbTag.push_back(tag);
    sbKind.push_back(kind);
    sbArg.push_back(arg);
    sbExp.push_back(exp);
  endtask

  task automatic popCheck(input int n);
    logic [31:0] obs;
    for (int i = 0; i < n; i++) begin
      if (sbKind.size() == 0) begin
        checkOutput("sb_underflow", 32'(0), 32'(1));
        return;
      end
      obs = '0;
      case (sbKind[0])
        K_ACC:     obs = 32'(acc);
        K_PC:      obs = 32'(pc);
        K_RET:     obs = 32'(retired);
        K_HALTED:  obs = 32'(halted);
        K_RUNNING: obs = 32'(running);
        K_READY:   obs = 32'(prog_ready);
        default: begin
          dbg_addr = 4'(sbArg[0]);
          #1;
          obs = 32'(dbg_data);
        end
      endcase
      checkOutput(sbTag[0], obs, sbExp[0]);
      void'(sbTag.pop_front());
      void'(sbKind.pop_front());
      void'(sbArg.pop_front());
      void'(sbExp.pop_front());
    end
  endtask

  task automatic waitHalt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("halt_reached", 32'(halted), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pushExp("rst_acc", K_ACC, 0, 0);
    pushExp("rst_pc", K_PC, 0, 0);
    pushExp("rst_retired", K_RET, 0, 0);
    pushExp("rst_running", K_RUNNING, 0, 0);
    pushExp("rst_halted", K_HALTED, 0, 0);
    pushExp("rst_ready", K_READY, 0, 1);
    pushExp("rst_dmem0", K_DBG, 0, 0);
    pushExp("rst_dbg15_pc", K_DBG, 15, 0);
    popCheck(sbKind.size());

    $display("[TB] LI 4 / SA r0 / HALT");
    progQ = '{8'h44, 8'h0F, 8'h08};
    loadProg();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    waitHalt(20, cyc);
    checkOutput("halt_latency_le4", 32'(cyc <= 4), 32'(1));
    pushExp("p1_acc", K_ACC, 0, 8'h04);
    pushExp("p1_dmem0", K_DBG, 0, 8'h04);
    pushExp("p1_retired", K_RET, 0, 3);
    pushExp("p1_pc", K_PC, 0, 2);
    pushExp("p1_running", K_RUNNING, 0, 0);
    pushExp("p1_ready", K_READY, 0, 1);
    popCheck(sbKind.size());

    $display("[TB] countdown loop with BNZ");
    progQ = '{8'h34, 8'hF2, 8'h13, 8'h08};
    loadProg();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    waitHalt(60, cyc);
    pushExp("loop_acc", K_ACC, 0, 0);
    pushExp("loop_pc", K_PC, 0, 3);
    pushExp("loop_retired", K_RET, 0, 8);
    pushExp("loop_dmem0_kept", K_DBG, 0, 8'h04);
    popCheck(sbKind.size());

    $display("[TB] shifts and SUB, per-cycle accumulator trace");
    progQ = '{8'h14, 8'h45, 8'h0F, 8'h84, 8'h15, 8'h46, 8'h07, 8'h08};
    loadProg();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    @(negedge clk);
    pushExp("tr_li1", K_ACC, 0, 8'h01);
    pushExp("tr_slli4", K_ACC, 0, 8'h10);
    pushExp("tr_sa", K_ACC, 0, 8'h10);
    pushExp("tr_li_m8", K_ACC, 0, 8'hF8);
    pushExp("tr_slli1", K_ACC, 0, 8'hF0);
    pushExp("tr_srli4", K_ACC, 0, 8'h0F);
    pushExp("tr_sub", K_ACC, 0, 8'hFF);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      popCheck(1);
    end
    waitHalt(20, cyc);
    pushExp("tr_dmem0", K_DBG, 0, 8'h10);
    pushExp("tr_retired", K_RET, 0, 8);
    pushExp("tr_pc", K_PC, 0, 7);
    popCheck(sbKind.size());

    $display("[TB] program write during RUN is ignored");
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    pushExp("run_running", K_RUNNING, 0, 1);
    pushExp("run_ready", K_READY, 0, 0);
    popCheck(2);
    applyStimulus(1'b1, 4'd2, 8'h08, 1'b0);
    waitHalt(40, cyc);
    pushExp("ign_acc", K_ACC, 0, 8'hFF);
    pushExp("ign_pc", K_PC, 0, 7);
    pushExp("ign_retired", K_RET, 0, 8);
    popCheck(sbKind.size());

    $display("[TB] write and start in the same cycle after halt");
    applyStimulus(1'b1, 4'd2, 8'h08, 1'b1);
    waitHalt(40, cyc);
    pushExp("wr_acc", K_ACC, 0, 8'h10);
    pushExp("wr_pc", K_PC, 0, 2);
    pushExp("wr_retired", K_RET, 0, 3);
    popCheck(sbKind.size());

    $display("[TB] out-of-range store, store/add forwarding, debug pc");
    progQ = '{8'h54, 8'hFF, 8'hFE, 8'h64, 8'hEF, 8'hE0, 8'h08};
    loadProg();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    waitHalt(40, cyc);
    pushExp("oor_acc", K_ACC, 0, 8'h0C);
    pushExp("oor_pc", K_PC, 0, 6);
    pushExp("oor_retired", K_RET, 0, 7);
    pushExp("oor_dmem14", K_DBG, 14, 8'h06);
    pushExp("oor_dbg15_pc", K_DBG, 15, 8'h06);
    pushExp("oor_dmem0", K_DBG, 0, 8'h10);
    popCheck(sbKind.size());

    $display("[TB] full imem without HALT wraps pc, then reset mid-run");
    progQ = {};
    for (int i = 0; i < 16; i++) progQ.push_back(8'h12);
    loadProg();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    pushExp("wrap_pc15", K_PC, 0, 15);
    pushExp("wrap_pc0", K_PC, 0, 0);
    pushExp("wrap_pc1", K_PC, 0, 1);
    pushExp("wrap_acc", K_ACC, 0, 8'h1C);
    pushExp("wrap_running", K_RUNNING, 0, 1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 15 || k == 16) popCheck(1);
      if (k == 17) popCheck(3);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pushExp("mrst_running", K_RUNNING, 0, 0);
    pushExp("mrst_halted", K_HALTED, 0, 0);
    pushExp("mrst_ready", K_READY, 0, 1);
    pushExp("mrst_acc", K_ACC, 0, 0);
    pushExp("mrst_pc", K_PC, 0, 0);
    pushExp("mrst_retired", K_RET, 0, 0);
    for (int a = 0; a < 15; a++) pushExp($sformatf("mrst_dmem%0d", a), K_DBG, a, 0);
    pushExp("mrst_dbg15_pc", K_DBG, 15, 0);
    popCheck(sbKind.size());
    @(negedge clk);
    pushExp("idle_running", K_RUNNING, 0, 0);
    pushExp("idle_pc", K_PC, 0, 0);
    popCheck(sbKind.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_acc_core.md
Name: tiny_acc_core

Overview:
- Parametrised second-generation accumulator processor core for the tiny processor family.
- Two-stage pipeline: fetch/decode, then execute/writeback.
- Generalised data width, instruction/data memory depths and operand width.
- Adds a run/idle/halt control FSM, a program-load port, HALT/SUB/SRLI instructions, a retired-instruction counter and a debug read port.
- Instantiated by the top-level tile wrapper, which drives the seven-segment mux from the debug port.

Parameters:
DATA_W, 8, accumulator/dmem word width (>=4)
OPND_W, 4, operand field width; INST_W = OPND_W+4
IMEM_DEPTH, 16, instruction words (2..2^OPND_W)
DMEM_DEPTH, 15, data words (1..2^OPND_W)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  pulse: begin execution at pc 0
prog_we  in  1  instruction write strobe
prog_addr  in  OPND_W  instruction write address
prog_data  in  OPND_W+4  instruction word
prog_ready  out  1  high when prog_we is accepted (state != RUN)
dbg_addr  in  OPND_W  debug dmem read address
dbg_data  out  DATA_W  debug read data (combinational)
pc  out  OPND_W  current fetch address
acc  out  DATA_W  accumulator
running  out  1  state == RUN
halted  out  1  state == HALT
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low at posedge clk):
  - state=IDLE, pc=0, acc=0, IR=NOP with ir_valid=0, retired=0.
  - All imem and dmem words cleared to 0.
  - Outputs: running=0, halted=0, prog_ready=1.
  - Reset mid-RUN aborts immediately; no store completes that cycle.
- Instruction format: opcode=inst[3:0], opnd=inst[INST_W-1:4]. imm = opnd sign-extended to DATA_W.
- FSM:
  - IDLE --start--> RUN
  - HALT --start--> RUN
  - RUN --HALT executes--> HALT
  - start in RUN is ignored.
  - On entry to RUN: pc<=0, IR<=NOP, ir_valid<=0, retired<=0. acc and dmem are retained.
- Program load: prog_we is accepted only in IDLE/HALT and writes imem[prog_addr]<=prog_data. It is ignored in RUN or when prog_addr>=IMEM_DEPTH. If prog_we and start arrive in the same cycle, the write completes and RUN begins next cycle.
- Fetch (RUN only):
  - inst=imem[pc]; IR<=inst, ir_valid<=1.
  - Next pc: if opcode==3 (BNZ) and the execute-stage alu_res!=0 (forwarded, same cycle), pc<=opnd; otherwise pc<=pc+1.
  - Increment wraps IMEM_DEPTH-1 -> 0. A branch target >= IMEM_DEPTH -> 0.
  - Fetched HALT (opcode 8): pc holds.
  - Outside RUN: pc holds and IR is loaded with NOP, ir_valid=0.
- Execute (alu_res combinational from IR; acc<=alu_res every cycle in RUN; acc holds otherwise):
  - 0 ADD: dmem[opnd]+acc
  - 1 NAND: ~(dmem[opnd]&acc)
  - 2 ADDI: acc+imm
  - 4 LI: imm
  - 5 SLLI: acc<<opnd mod DATA_W
  - 6 SRLI: acc>>opnd mod DATA_W (logical)
  - 7 SUB: acc-dmem[opnd]
  - E LA: dmem[opnd]
  - F SA: dmem[opnd]<=acc (old acc); alu_res=acc
  - 3, 8, other opcodes: alu_res=acc
  - All arithmetic is modulo 2^DATA_W.
  - dmem reads at addr>=DMEM_DEPTH return 0; stores to such addresses are dropped.
- HALT in execute: state<=HALT at that edge.
- Hazards: SA followed by LA/ADD to the same address reads the new value (the write lands before the next execute). BNZ uses the result of the immediately preceding instruction.
- retired: +1 each RUN cycle with ir_valid=1 (HALT counts). Saturates at all-ones.
- dbg_data = dmem[dbg_addr] if dbg_addr<DMEM_DEPTH, else zero-extended pc.

Test Plan:
- Reset, then load {0x44 LI 4, 0x0F SA r0, 0x08 HALT}, then start -> dmem[0]=0x04, acc=0x04, halted=1 within 4 cycles of start, retired=3.
- Program LI 3; ADDI -1; BNZ 1; HALT -> loop runs until acc=0, then halted, pc=3.
- LI -8 (0x84) -> acc=0xF8; SLLI 1 -> 0xF0; SRLI 4 -> 0x0F; SUB of dmem[0]=0x10 -> acc=0xFF.
- prog_we during RUN to addr 2 -> imem unchanged, prog_ready=0. The same write after halt takes effect, and start re-runs the program from pc 0 with retired reset.
- Store to address 15 (DMEM_DEPTH=15) dropped; dbg_addr=15 returns pc. Fill the program to IMEM_DEPTH-1 with no HALT -> pc wraps to 0.
- rst_n low for 1 cycle mid-RUN -> state IDLE, acc=0, all dmem=0, pc=0 on the next cycle.
